pads_out_ctrl: RTL and testbench

Parametrised, registered output-pad stage for the PPCU VLSI RISC-V chip, placed between core output signals (LEDs, UART TX, SPI, boot status) and the output pad ring. It holds every pad at a defined safe value until boot releases it. It then drives each pad from a per-channel mode: pass-through, forced low, forced high, or PWM-gated. A shared free-running PWM counter supports LED dimming. Under `KMIE_IMPLEMENT_ASIC` each channel drives one PDO12CDG pad cell; otherwise the pad is a plain wire from the output register.

---
 rtl/pads_out_ctrl.sv | 111 +++++++++++
 tb/tb_pads_out_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pads_out_ctrl.sv
// Registered output-pad stage: holds pads at a safe value until boot release,
// then drives each pad from a per-channel mode (pass, force low/high, PWM-gated).
module pads_out_ctrl #(
    parameter int               N_OUT     = 9,
    parameter int               PWM_W     = 8,
    parameter logic [N_OUT-1:0] RESET_VAL = {N_OUT{1'b0}},
    parameter int               SEL_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_OUT-1:0]   out_core,
    input  logic               release_i,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [1:0]         cfg_mode,
    input  logic [PWM_W-1:0]   cfg_duty,
    output logic [PWM_W+1:0]   cfg_rdata,
    output logic               released_o,
    output logic [N_OUT-1:0]   pad
);

    typedef enum logic [1:0] {
        MODE_PASS       = 2'b00,
        MODE_FORCE_LOW  = 2'b01,
        MODE_FORCE_HIGH = 2'b10,
        MODE_PWM        = 2'b11
    } mode_e;

    mode_e              mode_q [N_OUT];
    logic [PWM_W-1:0]   duty_q [N_OUT];
    logic [PWM_W-1:0]   cnt_q;
    logic               released_q;
    logic [N_OUT-1:0]   pwm_on;
    logic [N_OUT-1:0]   pad_d;
    logic [N_OUT-1:0]   pad_q;

    // Selects at or beyond N_OUT match no channel, so they neither write nor read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                mode_q[i] <= MODE_PASS;
                duty_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (cfg_we && (cfg_sel == SEL_W'(i))) begin
                    mode_q[i] <= mode_e'(cfg_mode);
                    duty_q[i] <= cfg_duty;
                end
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (cfg_sel == SEL_W'(i)) begin
                cfg_rdata = {mode_q[i], duty_q[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            released_q <= 1'b0;
            cnt_q      <= '0;
            pad_q      <= RESET_VAL;
        end else begin
            released_q <= released_q | release_i;
            cnt_q      <= cnt_q + PWM_W'(1);
            pad_q      <= pad_d;
        end
    end

    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < N_OUT; i++) begin
            pwm_on[i] = (cnt_q < duty_q[i]);
        end
    end

    // Uses the release flag as it stood before this edge, giving one extra safe cycle after release_i.
    always_comb begin
        pad_d = RESET_VAL;
        if (released_q) begin
            for (int i = 0; i < N_OUT; i++) begin
                case (mode_q[i])
                    MODE_PASS:       pad_d[i] = out_core[i];
                    MODE_FORCE_LOW:  pad_d[i] = 1'b0;
                    MODE_FORCE_HIGH: pad_d[i] = 1'b1;
                    MODE_PWM:        pad_d[i] = out_core[i] & pwm_on[i];
                    default:         pad_d[i] = RESET_VAL[i];
                endcase
            end
        end
    end

    assign released_o = released_q;

`ifdef KMIE_IMPLEMENT_ASIC
    for (genvar g = 0; g < N_OUT; g++) begin : g_pad
        PDO12CDG u_pad (
            .I   (pad_q[g]),
            .PAD (pad[g])
        );
    end
`else
    assign pad = pad_q;
`endif

endmodule

// File: tb/tb_pads_out_ctrl.sv
// Directed self-checking bench for pads_out_ctrl with hand-computed expectations.
module tb_pads_out_ctrl;

    localparam int         N_OUT = 9;
    localparam int         PWM_W = 8;
    localparam int         SEL_W = 4;
    localparam logic [8:0] RST_V = 9'h1A5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_OUT-1:0] out_core = '0;
    logic             release_i = 1'b0;
    logic             cfg_we = 1'b0;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic [1:0]       cfg_mode = '0;
    logic [PWM_W-1:0] cfg_duty = '0;
    logic [PWM_W+1:0] cfg_rdata;
    logic             released_o;
    logic [N_OUT-1:0] pad;

    int compareCount = 0;
    int mismatchCount = 0;

    pads_out_ctrl #(
        .N_OUT     (N_OUT),
        .PWM_W     (PWM_W),
        .RESET_VAL (RST_V)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_core   (out_core),
        .release_i  (release_i),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_mode   (cfg_mode),
        .cfg_duty   (cfg_duty),
        .cfg_rdata  (cfg_rdata),
        .released_o (released_o),
        .pad        (pad)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clocked config write; strobe dropped after the edge.
    task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [1:0] mode, input logic [PWM_W-1:0] duty);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_mode = mode;
        cfg_duty = duty;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic countPwm(input string tag, input int expected);
        int highs;
        highs = 0;
        for (int c = 0; c < 256; c++) begin
            tick();
            if (pad[0] === 1'b1) highs++;
        end
        checkOutput(tag, 32'(highs), 32'(expected));
    endtask

    logic [PWM_W+1:0] expRb [N_OUT];

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_pad", 32'(pad), 32'(RST_V));
        checkOutput("reset_released", 32'(released_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 50; i++) begin
            out_core = 9'(i * 37 + 1);
            tick();
            checkOutput("safe_pad", 32'(pad), 32'(RST_V));
            checkOutput("safe_released", 32'(released_o), 32'd0);
        end

        release_i = 1'b1;
        out_core  = 9'h0F0;
        tick();
        checkOutput("rel_flag", 32'(released_o), 32'd1);
        checkOutput("rel_still_safe", 32'(pad), 32'(RST_V));
        release_i = 1'b0;
        out_core  = 9'h10F;
        tick();
        checkOutput("rel_first_pass", 32'(pad), 32'h10F);
        out_core = 9'h0AA;
        tick();
        checkOutput("pass_latency", 32'(pad), 32'h0AA);
        checkOutput("rel_sticky", 32'(released_o), 32'd1);

        out_core = 9'h000;
        applyStimulus(4'd2, 2'b10, 8'h00);
        checkOutput("force_hi_edge_k", 32'(pad), 32'h000);
        tick();
        checkOutput("force_hi_edge_k1", 32'(pad), 32'h004);
        out_core = 9'h1FF;
        applyStimulus(4'd3, 2'b01, 8'h00);
        checkOutput("force_lo_edge_k", 32'(pad), 32'h1FF);
        tick();
        checkOutput("force_lo_edge_k1", 32'(pad), 32'h1F7);
        out_core = 9'h000;
        tick();
        checkOutput("force_zeros", 32'(pad), 32'h004);
        out_core = 9'h1FF;
        tick();
        checkOutput("force_ones", 32'(pad), 32'h1F7);

        cfg_sel = 4'd12;
        #1;
        checkOutput("bad_sel_rdata", 32'(cfg_rdata), 32'd0);
        applyStimulus(4'd12, 2'b11, 8'hAA);
        for (int i = 0; i < N_OUT; i++) expRb[i] = '0;
        expRb[2] = 10'h200;
        expRb[3] = 10'h100;
        for (int i = 0; i < N_OUT; i++) begin
            cfg_sel = 4'(i);
            #1;
            checkOutput($sformatf("readback_ch%0d", i), 32'(cfg_rdata), 32'(expRb[i]));
        end
        tick();
        checkOutput("bad_sel_pad", 32'(pad), 32'h1F7);

        applyStimulus(4'd0, 2'b11, 8'd64);
        countPwm("pwm_duty64", 64);
        applyStimulus(4'd0, 2'b11, 8'd0);
        countPwm("pwm_duty0", 0);
        applyStimulus(4'd0, 2'b11, 8'd255);
        countPwm("pwm_duty255", 255);
        out_core = 9'h1FE;
        countPwm("pwm_core_low", 0);

        out_core = 9'h1FF;
        applyStimulus(4'd0, 2'b11, 8'd64);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_pad", 32'(pad), 32'(RST_V));
        checkOutput("midrst_released", 32'(released_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cfg_sel = 4'(i);
            #1;
            checkOutput($sformatf("midrst_rb_ch%0d", i), 32'(cfg_rdata), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post_rst_safe", 32'(pad), 32'(RST_V));
        end

        out_core  = 9'h000;
        release_i = 1'b1;
        applyStimulus(4'd1, 2'b10, 8'h00);
        release_i = 1'b0;
        checkOutput("simul_safe", 32'(pad), 32'(RST_V));
        checkOutput("simul_flag", 32'(released_o), 32'd1);
        tick();
        checkOutput("simul_force", 32'(pad), 32'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
